// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit: holds HI/LO and models fixed MULT/DIV latency with a countdown.
// Optional MADD/MADDU support is enabled by defining MDU_MADD_EN.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MADDU = 3'b111;

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [63:0]        tmp_q, tmp_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] divisor, quot_s, rem_s, quot_u, rem_u;
  logic        div_zero;

  // Divisor forced non-zero so the divider never sees /0; the result is discarded then.
  assign div_zero = (B == 32'd0);
  assign divisor  = div_zero ? 32'd1 : B;
  assign prod_s   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u   = {32'd0, A} * {32'd0, B};
  assign quot_s   = $signed(A) / $signed(divisor);
  assign rem_s    = $signed(A) % $signed(divisor);
  assign quot_u   = A / divisor;
  assign rem_u    = A % divisor;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      tmp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      tmp_q   <= tmp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    tmp_d   = tmp_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          case (MDOp)
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            OP_MULT, OP_MULTU: begin
              tmp_d   = (MDOp == OP_MULT) ? prod_s : prod_u;
              cnt_d   = CNT_W'(MULT_CYCLES);
              busy_d  = 1'b1;
              state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              if (div_zero)            tmp_d = {hi_q, lo_q};
              else if (MDOp == OP_DIV) tmp_d = {rem_s, quot_s};
              else                     tmp_d = {rem_u, quot_u};
              cnt_d   = CNT_W'(DIV_CYCLES);
              busy_d  = 1'b1;
              state_d = RUN;
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
              tmp_d   = {hi_q, lo_q} + ((MDOp == OP_MADD) ? prod_s : prod_u);
              cnt_d   = CNT_W'(MULT_CYCLES);
              busy_d  = 1'b1;
              state_d = RUN;
            end
`else
            OP_MADD, OP_MADDU: ;
`endif
            default: ;
          endcase
        end
      end
      RUN: begin
        // Start is ignored here; commit happens on the edge the count reaches zero.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = tmp_q[63:32];
          lo_d    = tmp_q[31:0];
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multiply/divide unit for the five-stage MIPS pipeline, living in the EX stage next to the ALU. It accepts a signed or unsigned multiply, divide or multiply-accumulate from the EX-stage instruction and produces the `Busy` flag that the hazard unit combines with `StartE` to stall MD-class instructions in D. It also holds the architectural HI/LO registers that `mfhi`/`mflo` read. Results are computed with a fixed multi-cycle latency that is modelled by a countdown counter.

## Interface
- `MULT_CYCLES`, 5, cycles `Busy` stays high for MULT/MULTU/MADD/MADDU
- `DIV_CYCLES`, 10, cycles `Busy` stays high for DIV/DIVU

- `clk`  input  1  clock; all state updates on rising edge
- `reset_n`  input  1  synchronous, active-low reset
- `Start`  input  1  EX-stage instruction is an MD operation this cycle (same signal as `StartE`)
- `MDOp`  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MADDU
- `A`  input  32  forwarded rs value from EX
- `B`  input  32  forwarded rt value from EX
- `Busy`  output  1  operation in flight; HI/LO not yet updated
- `HI`  output  32  architectural HI register
- `LO`  output  32  architectural LO register

## Operation
- States: IDLE, RUN. Reset → IDLE, `Busy`=0, `HI`=0, `LO`=0, counter=0, temp result=0.
- IDLE, `Start`=1, `MDOp` in {MTHI, MTLO}: write `A` into HI or LO at this edge; stay IDLE; `Busy` stays 0.
- IDLE, `Start`=1, arithmetic op: latch the 64-bit result into the temp register {tHI,tLO}; load the counter with `MULT_CYCLES` or `DIV_CYCLES`; go to RUN.
  - MULT: {tHI,tLO} = signed A×B. MULTU: unsigned 64-bit product.
  - DIV: tLO = signed A/B (truncate toward zero), tHI = signed remainder (sign of A). DIVU: unsigned quotient and remainder.
  - MADD/MADDU: {tHI,tLO} = {HI,LO} + A×B (signed or unsigned product), mod 2^64.
  - Divide by zero (B=0): {tHI,tLO} = {HI,LO}, so HI and LO stay unchanged. Busy timing is still applied.
- RUN: `Busy`=1. The counter decrements each edge. On the edge where it reaches 0, copy {tHI,tLO} into {HI,LO} and return to IDLE.
- `Start` while in RUN: ignored entirely, including MTHI/MTLO. Neither the temp register nor HI/LO changes. The hazard unit prevents this case; the unit defines the behaviour anyway.
- HI/LO keep their old values for the whole of RUN.
- `reset_n`=0 at any edge, including mid-RUN: abort the operation and apply the full reset values.

## Timing
- `Start` is sampled at edge T0. `Busy` is a registered output and is 1 from T0+ through T(N−1)+, so it is high for exactly N cycles.
- At edge TN, HI/LO are updated and `Busy` drops to 0. New values are visible in the same cycle that `Busy` is low.
- Back-to-back: a new `Start` is accepted at edge TN+1, the first cycle with `Busy`=0.
- MTHI/MTLO: the new value is visible the cycle after the `Start` edge. Latency is 1.
- `HI`/`LO` are driven directly from registers, with no combinational path from `A`/`B`.

## Configuration
- `MDU_MADD_EN` defined: MDOp 110/111 perform MADD/MADDU as described above.
- `MDU_MADD_EN` undefined: MDOp 110/111 are treated as no-ops. They do not enter RUN, `Busy` stays 0, and HI/LO are unchanged.

## Test plan
- Reset, then MULT A=0xFFFFFFFE (−2), B=3 → `Busy` high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=−7 (0xFFFFFFF9), B=2 → `Busy` 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU with B=0 → HI/LO unchanged after 10 cycles.
- MTHI A=0x12345678 followed the next cycle by MTLO A=0x9ABCDEF0 → HI/LO visible 1 cycle after each write; `Busy` never asserted. Then `Start` with MTHI during a MULT's RUN → ignored, and HI equals the product at completion.
- MULT started, `reset_n`=0 on the 3rd busy cycle → next cycle `Busy`=0, HI=LO=0, and no late update occurs.
- With `MDU_MADD_EN`: HI=0, LO=0xFFFFFFFF, then MADDU A=1, B=1 → HI=1, LO=0 after 5 cycles. Without the macro: same stimulus → `Busy` stays 0 and HI/LO are unchanged.
